// File: rtl/uart_pkg.sv
// Shared definitions for the bus_uart block: register offsets inside the
// 16-byte window, STATUS bit positions, TX/RX FSM state encodings and a helper
// that turns the programmed divider into the divider actually used.
package uart_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;
  localparam logic [3:0] OFF_IRQ_EN = 4'hC;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_TX_BUSY   = 5;
  localparam int ST_FRAME_ERR = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A programmed divider of 0 behaves as 1 clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used for the TX and RX byte queues.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i/wdata_i  write request and data; ignored while full
//   pop_i           read request; ignored while empty
//   rdata_o         head entry (valid while !empty_o)
//   full_o/empty_o  occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART occupying one 16-byte slot behind the bus hub.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   addr/wdata/wmask/wen/ren  bus request from the hub
//   rdata/done      registered response
//   active          combinational window decode
//   uart_tx/uart_rx serial line (tx idles high, rx is asynchronous)
//   irq             level interrupt
// Build option: define UART_IRQ_EN to get the IRQ_EN register and irq output;
// otherwise irq is 0 and IRQ_EN reads 0 / ignores writes.
//
// Bus handshake: a strobe (wen or ren) is one clock wide and is only accepted
// when active=1; exactly one cycle later done pulses for one cycle with rdata
// holding the read result (rdata is 0 otherwise). There is no back-pressure.
module bus_uart
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        done,
  output logic        active,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  // ---------------- bus decode ----------------
  logic [31:0] rel_addr;
  logic [3:0]  off;
  logic        wr_acc, rd_acc;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign rel_addr = addr - BASE_ADDR;
  assign active   = (rel_addr < 32'd16);
  assign off      = rel_addr[3:0];
  assign wr_acc   = wen & active;
  assign rd_acc   = ren & active;

  // ---------------- FIFOs ----------------
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head, rx_shift_q, rx_shift_d;

  assign tx_push = wr_acc & (off == OFF_DATA) & wmask[0];
  assign rx_pop  = rd_acc & (off == OFF_DATA) & ~rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst), .push_i(tx_push), .wdata_i(wdata[7:0]),
    .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  logic rx_done;  // stop bit sampled high, byte complete
  assign rx_push = rx_done & ~rx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst), .push_i(rx_push), .wdata_i(rx_shift_q),
    .pop_i(rx_pop), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // ---------------- registers ----------------
  logic [15:0] div_q, div_d, div_eff, div_last, rx_half_last;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [1:0]  irq_en_rd;
  logic        frame_set, tx_busy;
  logic        status_wr;

  assign div_eff      = eff_div(div_q);
  assign div_last     = div_eff - 16'd1;
  assign rx_half_last = ((div_eff >> 1) == 16'd0) ? 16'd0 : (div_eff >> 1) - 16'd1;
  assign status_wr    = wr_acc & (off == OFF_STATUS) & wmask[0];

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA:   if (!rx_empty) rd_val = {1'b1, 23'b0, rx_head};
      OFF_STATUS: begin
        rd_val[ST_TX_FULL]   = tx_full;
        rd_val[ST_TX_EMPTY]  = tx_empty;
        rd_val[ST_RX_EMPTY]  = rx_empty;
        rd_val[ST_RX_FULL]   = rx_full;
        rd_val[ST_OVERRUN]   = overrun_q;
        rd_val[ST_TX_BUSY]   = tx_busy;
        rd_val[ST_FRAME_ERR] = frame_err_q;
      end
      OFF_DIV:    rd_val = {16'b0, div_q};
      OFF_IRQ_EN: rd_val = {30'b0, irq_en_rd};
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    div_d       = div_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    done_d      = wr_acc | rd_acc;
    rdata_d     = rd_acc ? rd_val : 32'h0;
    if (wr_acc && off == OFF_DIV) begin
      if (wmask[0]) div_d[7:0]  = wdata[7:0];
      if (wmask[1]) div_d[15:8] = wdata[15:8];
    end
    // Clear first so a same-cycle hardware set takes priority.
    if (status_wr && wdata[ST_OVERRUN])   overrun_d   = 1'b0;
    if (status_wr && wdata[ST_FRAME_ERR]) frame_err_d = 1'b0;
    if (rx_done && rx_full) overrun_d   = 1'b1;
    if (frame_set)          frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= DEFAULT_DIV;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign done  = done_q;
  assign rdata = rdata_q;

`ifdef UART_IRQ_EN
  logic [1:0] irq_en_q;
  logic       irq_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      if (wr_acc && off == OFF_IRQ_EN && wmask[0]) irq_en_q <= wdata[1:0];
      irq_q <= (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
    end
  end
  assign irq_en_rd = irq_en_q;
  assign irq       = irq_q;
`else
  assign irq_en_rd = 2'b00;
  assign irq       = 1'b0;
`endif

  // ---------------- TX FSM ----------------
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q >= div_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q >= div_last) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt_q >= div_last) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave
          // without an idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is registered from the next state so uart_tx is glitch-free.
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;

  // ---------------- RX FSM ----------------
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Re-check the start bit half a bit in; a high line was a glitch.
        if (rx_cnt_q >= rx_half_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q >= div_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q >= div_last) begin
          rx_cnt_d   = '0;
          rx_done    = rx_s2_q;
          frame_set  = ~rx_s2_q;
          rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Upper data bits and byte lanes 2/3 have no register behind them.
  logic unused_bits;
  assign unused_bits = ^{wdata[31:16], wmask[3:2]};

endmodule
